// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round-constant table, key-expander
// FSM state type and the 128-bit key type. Used by the key expander and
// available to the cipher core.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [127:0] key128_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } kx_state_t;

    // Round constants Rcon[1..10]; element 1 is the leftmost byte.
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // RotWord: cyclic left rotation of a 32-bit word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte substitution.
// Shared between the key expander (SubWord) and the cipher core.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Byte 0x00 maps through the leftmost entry, 0xff through the rightmost.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup.
    always_comb begin
        dout = SBOX_TABLE[din];
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expander: on an accepted start, stores the cipher key as round
// key 0 and derives round keys 1..10 at one per clock, then pulses key_done.
// Round keys are readable by index at any time; key_valid marks a complete set.
// Optional macro AES_KEY_RDREG_EN registers rd_key (1-cycle read latency);
// without it rd_key is combinational from rd_round.
module aes_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_start,
    input  logic         key_mode,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         key_done,
    output logic         key_busy,
    output logic         key_valid
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    kx_state_t    state;
    logic [3:0]   round;
    key128_t      work;
    key128_t      round_keys [0:NR];

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  temp;
    logic [7:0]   rcon_sel;
    key128_t      next_key;
    key128_t      rd_sel;

    assign w0  = work[127:96];
    assign w1  = work[95:64];
    assign w2  = work[63:32];
    assign w3  = work[31:0];
    assign rot = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    // Next round key from the previous one held in the working register.
    always_comb begin
        rcon_sel = '0;
        if (round >= 4'd1 && round <= LAST_ROUND) begin
            rcon_sel = RCON[round];
        end
        temp     = sub ^ {rcon_sel, 24'h000000};
        next_key = '0;
        next_key[127:96] = w0 ^ temp;
        next_key[95:64]  = w1 ^ w0 ^ temp;
        next_key[63:32]  = w2 ^ w1 ^ w0 ^ temp;
        next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
    end

    // Control FSM with registered flags and round-key storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round     <= '0;
            key_done  <= 1'b0;
            key_busy  <= 1'b0;
            key_valid <= 1'b0;
            work      <= '0;
            for (int unsigned i = 0; i <= NR; i++) begin
                round_keys[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    key_done <= 1'b0;
                    if (key_start && !key_mode) begin
                        round_keys[0] <= key_in;
                        work          <= key_in;
                        round         <= 4'd1;
                        key_valid     <= 1'b0;
                        key_busy      <= 1'b1;
                        state         <= EXPAND;
                    end
                end
                EXPAND: begin
                    round_keys[round] <= next_key;
                    work              <= next_key;
                    if (round == LAST_ROUND) begin
                        key_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    key_done  <= 1'b0;
                    key_busy  <= 1'b0;
                    key_valid <= 1'b1;
                    round     <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-port selection; indices beyond the last round read as zero.
    always_comb begin
        rd_sel = '0;
        if (rd_round <= LAST_ROUND) begin
            rd_sel = round_keys[rd_round];
        end
    end

`ifdef AES_KEY_RDREG_EN
    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key <= '0;
        end else begin
            rd_key <= rd_sel;
        end
    end
`else
    // Combinational read port.
    always_comb begin
        rd_key = rd_sel;
    end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander. The reference model derives the
// S-box from GF(2^8) inversion plus the affine map, generates Rcon by
// repeated doubling, and expands keys word by word as in FIPS-197.
// Read latency expectations follow AES_KEY_RDREG_EN.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_start;
    logic         key_mode;
    logic [127:0] key_in;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         key_done;
    logic         key_busy;
    logic         key_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_ref [0:255];
    logic [127:0] model_rk [0:10];

    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KAT_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expander dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_mode  (key_mode),
        .key_in    (key_in),
        .rd_round  (rd_round),
        .rd_key    (rd_key),
        .key_done  (key_done),
        .key_busy  (key_busy),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic void build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic read_key(input logic [3:0] idx, output logic [127:0] val);
        rd_round = idx;
`ifdef AES_KEY_RDREG_EN
        @(posedge clk); #1;
`else
        @(negedge clk);
`endif
        val = rd_key;
    endtask

    // Start an expansion and watch the flags for 14 cycles after acceptance.
    // inj bit c pulses key_start (mode 0, different key) before edge c.
    task automatic run_expansion(input logic [127:0] key, input logic [15:0] inj, input string tag);
        int   done_count;
        int   first_done;
        logic exp_busy, exp_valid;
        key_in = key; key_mode = 1'b0; key_start = 1'b1;
        @(posedge clk); #1;
        key_start = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        checks++;
        if (key_busy !== 1'b1 || key_valid !== 1'b0 || key_done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept_flags: busy=%b valid=%b done=%b expected 1 0 0",
                     tag, key_busy, key_valid, key_done);
        end
        done_count = 0; first_done = -1;
        for (int c = 1; c <= 14; c++) begin
            key_start = inj[c]; key_mode = 1'b0;
            if (inj[c]) key_in = ~key;
            @(posedge clk); #1;
            if (key_done === 1'b1) begin
                done_count++;
                if (first_done < 0) first_done = c;
            end
            exp_busy  = (c <= 10);
            exp_valid = (c >= 11);
            checks++;
            if (key_busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy@%0d: got %b expected %b", tag, c, key_busy, exp_busy);
            end
            checks++;
            if (key_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s valid@%0d: got %b expected %b", tag, c, key_valid, exp_valid);
            end
        end
        key_start = 1'b0;
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", tag, done_count);
        end
        // Latency counts the acceptance edge as clock 1.
        checks++;
        if (first_done + 1 != 11) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected 11", tag, first_done + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [127:0] v;
        rst = 1'b1; key_start = 1'b0; key_mode = 1'b0; key_in = '0; rd_round = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (key_done !== 1'b0 || key_busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: done=%b busy=%b valid=%b expected 0 0 0",
                     key_done, key_busy, key_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_key(4'(i), v);
            checks++;
            if (v !== 128'h0) begin
                errors++;
                $display("FAIL reset_rd[%0d]: got %h expected 0", i, v);
            end
        end
    endtask

    task automatic test_known_vector();
        logic [127:0] v, exp;
        run_expansion(KAT_KEY, 16'h0000, "kat");
        build_model(KAT_KEY);
        read_key(4'd1, v);
        checks++;
        if (v !== KAT_R1) begin
            errors++; $display("FAIL kat_r1: got %h expected %h", v, KAT_R1);
        end
        read_key(4'd10, v);
        checks++;
        if (v !== KAT_R10) begin
            errors++; $display("FAIL kat_r10: got %h expected %h", v, KAT_R10);
        end
        for (int i = 0; i < 16; i++) begin
            read_key(4'(i), v);
            exp = (i <= 10) ? model_rk[i] : 128'h0;
            checks++;
            if (v !== exp) begin
                errors++; $display("FAIL kat_rd[%0d]: got %h expected %h", i, v, exp);
            end
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL kat_valid: got %b expected 1", key_valid);
        end
    endtask

    task automatic test_start_during_expand();
        logic [127:0] v;
        // Extra starts at clocks 3 and 7 of EXPAND, and one while in DONE.
        run_expansion(KAT_KEY, 16'h0888, "restart");
        build_model(KAT_KEY);
        read_key(4'd1, v);
        checks++;
        if (v !== KAT_R1) begin
            errors++; $display("FAIL restart_r1: got %h expected %h", v, KAT_R1);
        end
        read_key(4'd10, v);
        checks++;
        if (v !== KAT_R10) begin
            errors++; $display("FAIL restart_r10: got %h expected %h", v, KAT_R10);
        end
        for (int i = 0; i <= 10; i++) begin
            read_key(4'(i), v);
            checks++;
            if (v !== model_rk[i]) begin
                errors++; $display("FAIL restart_rd[%0d]: got %h expected %h", i, v, model_rk[i]);
            end
        end
    endtask

    task automatic test_mode_hold();
        logic [127:0] v;
        key_mode = 1'b1; key_start = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (key_busy !== 1'b0 || key_done !== 1'b0 || key_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_flags@%0d: busy=%b done=%b valid=%b expected 0 0 1",
                         c, key_busy, key_done, key_valid);
            end
        end
        key_start = 1'b0; key_mode = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_key(4'(i), v);
            checks++;
            if (v !== model_rk[i]) begin
                errors++; $display("FAIL hold_rd[%0d]: got %h expected %h", i, v, model_rk[i]);
            end
        end
        read_key(4'd12, v);
        checks++;
        if (v !== 128'h0) begin
            errors++; $display("FAIL hold_rd12: got %h expected 0", v);
        end
    endtask

    task automatic test_zero_key();
        logic [127:0] v;
        run_expansion(128'h0, 16'h0000, "zero");
        build_model(128'h0);
        read_key(4'd10, v);
        checks++;
        if (v !== ZERO_R10) begin
            errors++; $display("FAIL zero_r10: got %h expected %h", v, ZERO_R10);
        end
        read_key(4'd5, v);
        checks++;
        if (v !== model_rk[5]) begin
            errors++; $display("FAIL zero_r5: got %h expected %h", v, model_rk[5]);
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL zero_valid: got %b expected 1", key_valid);
        end
    endtask

    task automatic test_random_keys();
        logic [127:0] key, v, exp;
        logic [15:0]  inj;
        for (int n = 0; n < 4; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            inj = 16'($urandom) & 16'h0ffe;
            run_expansion(key, inj, "rand");
            build_model(key);
            for (int i = 0; i < 16; i++) begin
                read_key(4'(i), v);
                exp = (i <= 10) ? model_rk[i] : 128'h0;
                checks++;
                if (v !== exp) begin
                    errors++; $display("FAIL rand%0d_rd[%0d]: got %h expected %h", n, i, v, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_expand();
        logic [127:0] key, v, exp;
        key = {$urandom, $urandom, $urandom, 32'h0000_0001};
        rd_round = 4'd0;
        key_in = key; key_mode = 1'b0; key_start = 1'b1;
        @(posedge clk); #1;
        key_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (key_busy !== 1'b1 || rd_key !== key) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b rd=%h expected 1 %h", key_busy, rd_key, key);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (key_done !== 1'b0 || key_busy !== 1'b0 || key_valid !== 1'b0 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL midrst_outputs: done=%b busy=%b valid=%b rd=%h expected all 0",
                     key_done, key_busy, key_valid, rd_key);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_key(4'(i), v);
            checks++;
            if (v !== 128'h0) begin
                errors++; $display("FAIL midrst_rd[%0d]: got %h expected 0", i, v);
            end
        end
        key = {$urandom, $urandom, $urandom, $urandom};
        run_expansion(key, 16'h0000, "after_rst");
        build_model(key);
        for (int i = 0; i <= 10; i++) begin
            read_key(4'(i), v);
            exp = model_rk[i];
            checks++;
            if (v !== exp) begin
                errors++; $display("FAIL after_rst_rd[%0d]: got %h expected %h", i, v, exp);
            end
        end
    endtask

    task automatic test_rd_latency();
        logic [127:0] v, exp_now;
        @(posedge clk); #1;
        rd_round = 4'd2;
        @(posedge clk); #1;
        rd_round = 4'd9;
        #2;
        v = rd_key;
`ifdef AES_KEY_RDREG_EN
        exp_now = model_rk[2];
`else
        exp_now = model_rk[9];
`endif
        checks++;
        if (v !== exp_now) begin
            errors++; $display("FAIL lat_same_cycle: got %h expected %h", v, exp_now);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_key !== model_rk[9]) begin
            errors++; $display("FAIL lat_next_cycle: got %h expected %h", rd_key, model_rk[9]);
        end
        rd_round = 4'd11;
        #2;
        v = rd_key;
`ifdef AES_KEY_RDREG_EN
        exp_now = model_rk[9];
`else
        exp_now = 128'h0;
`endif
        checks++;
        if (v !== exp_now) begin
            errors++; $display("FAIL lat_oob_same_cycle: got %h expected %h", v, exp_now);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_key !== 128'h0) begin
            errors++; $display("FAIL lat_oob_next_cycle: got %h expected 0", rd_key);
        end
    endtask

    initial begin
        for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_calc(8'(x));
        test_reset();
        test_known_vector();
        test_start_during_expand();
        test_mode_hold();
        test_zero_key();
        test_random_keys();
        test_reset_mid_expand();
        test_rd_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
